// File: rtl/fmeter_pkg.sv
// Shared types and constants for the frequency meter sequencer.
// Gate selections, ASCII framing and message helpers.
package fmeter_pkg;

  typedef enum logic [1:0] {
    GSEL_10MS  = 2'd0,
    GSEL_100MS = 2'd1,
    GSEL_1S    = 2'd2,
    GSEL_10S   = 2'd3
  } gate_sel_e;

  typedef enum logic [1:0] {
    G_CLEAR  = 2'd0,
    G_GATE   = 2'd1,
    G_SETTLE = 2'd2,
    G_LATCH  = 2'd3
  } gate_st_e;

  typedef enum logic {
    T_IDLE = 1'b0,
    T_SEND = 1'b1
  } tx_st_e;

  localparam int DIGITS  = 8;
  localparam int MSG_LEN = DIGITS + 2;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_BAD  = 8'h3F;

  localparam logic [10:0] DECADE_LIM [4] = '{
    11'd1, 11'd10, 11'd100, 11'd1000
  };

  // Last decade count value for a gate selection.
  function automatic logic [9:0] decade_max(
    input gate_sel_e sel
  );
    return 10'(DECADE_LIM[sel] - 11'd1);
  endfunction

  // One BCD digit as ASCII, '?' when not decimal.
  function automatic logic [7:0] digit_ascii(
    input logic [3:0] d
  );
    return (d > 4'd9) ? ASCII_BAD
                      : ASCII_ZERO + {4'd0, d};
  endfunction

  // Byte at message position: 0..7 digits MSD
  // first, 8 = CR, 9 = LF.
  function automatic logic [7:0] msg_byte(
    input logic [31:0] snap,
    input logic [3:0]  pos
  );
    logic [31:0] s;
    logic [7:0]  b;
    s = snap << {pos[2:0], 2'b00};
    b = ASCII_LF;
    unique case (1'b1)
      (pos < 4'd8):  b = digit_ascii(s[31:28]);
      (pos == 4'd8): b = ASCII_CR;
      default:       b = ASCII_LF;
    endcase
    return b;
  endfunction

  // First position to send with leading-zero
  // suppression; digit 0 is always sent.
  function automatic logic [3:0] lz_start(
    input logic [31:0] snap
  );
    logic [3:0] p;
    p = 4'(DIGITS - 1);
    for (int i = DIGITS - 2; i >= 0; i--) begin
      if (snap[(DIGITS - 1 - i) * 4 +: 4] != 4'd0)
        p = 4'(i);
    end
    return p;
  endfunction

endpackage

// File: rtl/fmeter_ctrl_tx_seq.sv
// Snapshot buffer and ASCII byte streamer.
// Drops snapshots that arrive while a message is in flight.
module fmeter_tx_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        snap_req,
  input  logic [31:0] snap_data,
  input  logic        lz_suppress,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        overrun
);
  import fmeter_pkg::*;

  tx_st_e      state;
  logic [31:0] snap_q;
  logic [3:0]  pos;
  logic [3:0]  start_pos;
  logic        xfer;
  logic        last;

  assign start_pos = lz_suppress ? lz_start(snap_data)
                                 : 4'd0;
  assign xfer = tx_valid & tx_ready;
  assign last = (pos == 4'(MSG_LEN - 1));

  // Load on request when idle, advance one byte per transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= T_IDLE;
      snap_q   <= '0;
      pos      <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= snap_req && (state == T_SEND);
      unique case (state)
        T_IDLE: begin
          if (snap_req) begin
            snap_q   <= snap_data;
            pos      <= start_pos;
            tx_data  <= msg_byte(snap_data, start_pos);
            tx_valid <= 1'b1;
            state    <= T_SEND;
          end
        end
        T_SEND: begin
          if (xfer) begin
            if (last) begin
              tx_valid <= 1'b0;
              pos      <= '0;
              state    <= T_IDLE;
            end else begin
              pos     <= pos + 4'd1;
              tx_data <= msg_byte(snap_q, pos + 4'd1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/fmeter_ctrl.sv
// Frequency meter gate sequencer: clear, gate, settle, latch,
// with the snapshot streamed out as ASCII text.
module fmeter_ctrl #(
  parameter int GATE_10MS = 1000000,
  parameter int DIGITS    = 8
) (
  input  logic                  CLK100MHz,
  input  logic                  RSTn,
  input  logic [1:0]            GATE_SEL,
  input  logic                  LZ_SUPPRESS,
  output logic                  CNT_CLR,
  output logic                  CNT_EN,
  input  logic [4*DIGITS-1:0]   CNT_BCD,
  output logic [7:0]            TX_DATA,
  output logic                  TX_VALID,
  input  logic                  TX_READY,
  output logic                  GATE_LED,
  output logic                  OVERRUN
);
  import fmeter_pkg::*;

  localparam int TW = (GATE_10MS > 1) ? $clog2(GATE_10MS) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(GATE_10MS - 1);

  gate_st_e  state;
  gate_sel_e gate_len;
  logic [TW-1:0] tick;
  logic [9:0]    dec;
  logic          snap_req;
  logic          tick_last;
  logic          dec_last;

  assign tick_last = (tick == TICK_MAX);
  assign dec_last  = (dec == decade_max(gate_len));

  // The state names the phase the next edge starts, so each
  // registered output lines up with its phase cycle.
  always_ff @(posedge CLK100MHz or negedge RSTn) begin
    if (!RSTn) begin
      state    <= G_CLEAR;
      gate_len <= GSEL_10MS;
      tick     <= '0;
      dec      <= '0;
      CNT_CLR  <= 1'b0;
      CNT_EN   <= 1'b0;
      GATE_LED <= 1'b0;
      snap_req <= 1'b0;
    end else begin
      CNT_CLR  <= 1'b0;
      snap_req <= 1'b0;
      unique case (state)
        G_CLEAR: begin
          CNT_CLR  <= 1'b1;
          CNT_EN   <= 1'b0;
          gate_len <= gate_sel_e'(GATE_SEL);
          tick     <= '0;
          dec      <= '0;
          state    <= G_GATE;
        end
        G_GATE: begin
          CNT_EN <= 1'b1;
          if (tick_last) begin
            tick <= '0;
            if (dec_last) begin
              dec   <= '0;
              state <= G_SETTLE;
            end else begin
              dec <= dec + 10'd1;
            end
          end else begin
            tick <= tick + TW'(1);
          end
        end
        G_SETTLE: begin
          CNT_EN <= 1'b0;
          state  <= G_LATCH;
        end
        G_LATCH: begin
          GATE_LED <= ~GATE_LED;
          snap_req <= 1'b1;
          state    <= G_CLEAR;
        end
      endcase
    end
  end

  fmeter_tx_seq u_tx (
    .clk         (CLK100MHz),
    .rst_n       (RSTn),
    .snap_req    (snap_req),
    .snap_data   (CNT_BCD),
    .lz_suppress (LZ_SUPPRESS),
    .tx_data     (TX_DATA),
    .tx_valid    (TX_VALID),
    .tx_ready    (TX_READY),
    .overrun     (OVERRUN)
  );

endmodule

// File: tb/tb_fmeter_ctrl.sv
// Bench for fmeter_ctrl: gate timing, ASCII stream, stalls,
// overrun and asynchronous reset against a behavioural model.
module tb_fmeter_ctrl;

  logic        CLK100MHz = 1'b0;
  logic        RSTn = 1'b0;
  logic [1:0]  GATE_SEL = 2'd0;
  logic        LZ_SUPPRESS = 1'b0;
  logic        CNT_CLR;
  logic        CNT_EN;
  logic [31:0] CNT_BCD = 32'd0;
  logic [7:0]  TX_DATA;
  logic        TX_VALID;
  logic        TX_READY = 1'b1;
  logic        GATE_LED;
  logic        OVERRUN;

  fmeter_ctrl #(.GATE_10MS(10), .DIGITS(8)) dut (
    .CLK100MHz   (CLK100MHz),
    .RSTn        (RSTn),
    .GATE_SEL    (GATE_SEL),
    .LZ_SUPPRESS (LZ_SUPPRESS),
    .CNT_CLR     (CNT_CLR),
    .CNT_EN      (CNT_EN),
    .CNT_BCD     (CNT_BCD),
    .TX_DATA     (TX_DATA),
    .TX_VALID    (TX_VALID),
    .TX_READY    (TX_READY),
    .GATE_LED    (GATE_LED),
    .OVERRUN     (OVERRUN)
  );

  always #5 CLK100MHz = ~CLK100MHz;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int en_run = 0;
  int ov_cnt = 0;
  int stall_err = 0;
  int clr_q[$];
  int en_q[$];
  int rxc_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  logic pv = 1'b0;
  logic pr = 1'b0;
  logic [7:0] pd = 8'd0;
  bit rand_ready = 1'b0;

  // observe at the falling edge; inputs only move just after rising edges
  always @(negedge CLK100MHz) begin
    cyc++;
    if (!RSTn) begin
      en_run = 0;
      pv = 1'b0;
    end else begin
      if (CNT_CLR) clr_q.push_back(cyc);
      if (CNT_EN) en_run++;
      else if (en_run != 0) begin
        en_q.push_back(en_run);
        en_run = 0;
      end
      if (OVERRUN) ov_cnt++;
      if (pv && !pr && (!TX_VALID || TX_DATA !== pd))
        stall_err++;
      if (TX_VALID && TX_READY) begin
        rx_q.push_back(TX_DATA);
        rxc_q.push_back(cyc);
      end
      pv = TX_VALID;
      pr = TX_READY;
      pd = TX_DATA;
    end
  end

  always @(posedge CLK100MHz) begin
    #1;
    if (rand_ready) TX_READY = 1'($urandom_range(0, 1));
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // expected text: digits MSD first, leading zeros dropped if asked
  function automatic void model_msg(input logic [31:0] v,
                                    input bit lz);
    bit lead;
    logic [3:0] d;
    lead = lz;
    for (int i = 7; i >= 0; i--) begin
      d = v[i*4 +: 4];
      if (lead && d == 4'd0 && i != 0) continue;
      lead = 1'b0;
      exp_q.push_back(d > 4'd9 ? 8'h3F : 8'h30 + 8'(d));
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endfunction

  function automatic logic [31:0] rand_val();
    logic [31:0] v;
    int nz;
    v = 32'd0;
    nz = $urandom_range(0, 8);
    for (int i = 0; i < 8; i++) begin
      v = v << 4;
      if (i >= nz)
        v[3:0] = ($urandom_range(0, 7) == 0)
                 ? 4'($urandom_range(10, 15))
                 : 4'($urandom_range(0, 9));
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge CLK100MHz);
    #1;
  endtask

  task automatic wait_clr(input int lim, input string nm);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!CNT_CLR && n < lim);
    total_cnt++;
    if (CNT_CLR !== 1'b1)
      $display("FAIL %s: no CNT_CLR within %0d cycles", nm, lim);
    else pass_cnt++;
  endtask

  task automatic do_reset(input logic [1:0] sel);
    RSTn = 1'b0;
    GATE_SEL = sel;
    TX_READY = 1'b1;
    LZ_SUPPRESS = 1'b0;
    CNT_BCD = 32'd0;
    tick();
    tick();
    clr_q.delete();
    en_q.delete();
    rx_q.delete();
    rxc_q.delete();
    exp_q.delete();
    ov_cnt = 0;
    stall_err = 0;
    RSTn = 1'b1;
  endtask

  task automatic test_reset();
    RSTn = 1'b0;
    GATE_SEL = 2'd0;
    TX_READY = 1'b1;
    tick();
    tick();
    total_cnt++;
    if ({CNT_CLR, CNT_EN, GATE_LED, OVERRUN} !== 4'b0)
      $display("FAIL reset_ctl: got %b want 0000",
               {CNT_CLR, CNT_EN, GATE_LED, OVERRUN});
    else pass_cnt++;
    total_cnt++;
    if ({TX_VALID, TX_DATA} !== 9'd0)
      $display("FAIL reset_tx: got %h want 000",
               {TX_VALID, TX_DATA});
    else pass_cnt++;
    clr_q.delete();
    en_q.delete();
    RSTn = 1'b1;
    tick();
    total_cnt++;
    if ({CNT_CLR, CNT_EN} !== 2'b10)
      $display("FAIL first_clr: got %b want 10",
               {CNT_CLR, CNT_EN});
    else pass_cnt++;
  endtask

  task automatic test_gate_timing();
    repeat (5) wait_clr(20, "gate_period");
    tick();
    total_cnt++;
    if (clr_q.size() != 6)
      $display("FAIL clr_count: got %0d want 6", clr_q.size());
    else pass_cnt++;
    for (int i = 0; i + 1 < clr_q.size(); i++) begin
      total_cnt++;
      if (clr_q[i+1] - clr_q[i] != 13)
        $display("FAIL clr_interval %0d: got %0d want 13",
                 i, clr_q[i+1] - clr_q[i]);
      else pass_cnt++;
    end
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (en_q[i] != 10)
        $display("FAIL en_len %0d: got %0d want 10", i, en_q[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_gate_sel();
    do_reset(2'd2);
    wait_clr(5, "sel_first_clr");
    repeat (500) tick();
    GATE_SEL = 2'd0;
    wait_clr(1100, "sel_long_gate");
    wait_clr(20, "sel_short_gate");
    tick();
    total_cnt++;
    if (en_q[0] != 1000)
      $display("FAIL en_len_1s: got %0d want 1000", en_q[0]);
    else pass_cnt++;
    total_cnt++;
    if (en_q[1] != 10)
      $display("FAIL en_len_after_sel: got %0d want 10", en_q[1]);
    else pass_cnt++;
    total_cnt++;
    if (clr_q[1] - clr_q[0] != 1003)
      $display("FAIL period_1s: got %0d want 1003",
               clr_q[1] - clr_q[0]);
    else pass_cnt++;
    total_cnt++;
    if (clr_q[2] - clr_q[1] != 13)
      $display("FAIL period_10ms: got %0d want 13",
               clr_q[2] - clr_q[1]);
    else pass_cnt++;
  endtask

  task automatic test_tx_format();
    logic [31:0] vals [7];
    bit lzs [7];
    vals = '{32'h00123456, 32'h00123456, 32'h0000000A,
             32'h00000000, 32'h00000000, 32'h9A0B00C1,
             32'h000E0000};
    lzs = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    do_reset(2'd0);
    for (int k = 0; k < 7; k++) begin
      wait_clr(20, "fmt_clr");
      CNT_BCD = vals[k];
      LZ_SUPPRESS = lzs[k];
      model_msg(vals[k], lzs[k]);
    end
    wait_clr(20, "fmt_last");
    repeat (10) tick();
    total_cnt++;
    if (rx_q.size() != exp_q.size())
      $display("FAIL fmt_len: got %0d want %0d",
               rx_q.size(), exp_q.size());
    else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      total_cnt++;
      if (rx_q[i] !== exp_q[i])
        $display("FAIL fmt_byte %0d: got %h want %h",
                 i, rx_q[i], exp_q[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (rxc_q[9] - rxc_q[0] != 9)
      $display("FAIL fmt_b2b: got span %0d want 9",
               rxc_q[9] - rxc_q[0]);
    else pass_cnt++;
    total_cnt++;
    if (ov_cnt != 0)
      $display("FAIL fmt_overrun: got %0d want 0", ov_cnt);
    else pass_cnt++;
  endtask

  task automatic test_stall_random();
    logic [31:0] v;
    bit lz;
    int n;
    do_reset(2'd1);
    rand_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wait_clr(120, "rnd_clr");
      v = rand_val();
      lz = 1'($urandom_range(0, 1));
      CNT_BCD = v;
      LZ_SUPPRESS = lz;
      model_msg(v, lz);
    end
    wait_clr(120, "rnd_last");
    n = 0;
    while (rx_q.size() < exp_q.size() && n < 300) begin
      tick();
      n++;
    end
    rand_ready = 1'b0;
    TX_READY = 1'b1;
    total_cnt++;
    if (rx_q.size() != exp_q.size())
      $display("FAIL rnd_len: got %0d want %0d",
               rx_q.size(), exp_q.size());
    else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      total_cnt++;
      if (rx_q[i] !== exp_q[i])
        $display("FAIL rnd_byte %0d: got %h want %h",
                 i, rx_q[i], exp_q[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (stall_err != 0)
      $display("FAIL rnd_stall_hold: got %0d want 0", stall_err);
    else pass_cnt++;
    total_cnt++;
    if (ov_cnt != 0)
      $display("FAIL rnd_overrun: got %0d want 0", ov_cnt);
    else pass_cnt++;
  endtask

  task automatic test_overrun_hold();
    do_reset(2'd0);
    wait_clr(20, "ovr_clr0");
    CNT_BCD = 32'h00004321;
    LZ_SUPPRESS = 1'b0;
    TX_READY = 1'b0;
    model_msg(32'h00004321, 1'b0);
    wait_clr(20, "ovr_clr1");
    CNT_BCD = 32'h11111111;
    wait_clr(20, "ovr_clr2");
    TX_READY = 1'b1;
    CNT_BCD = 32'h00000707;
    LZ_SUPPRESS = 1'b1;
    model_msg(32'h00000707, 1'b1);
    wait_clr(20, "ovr_clr3");
    repeat (10) tick();
    total_cnt++;
    if (ov_cnt != 1)
      $display("FAIL ovr_pulses: got %0d want 1", ov_cnt);
    else pass_cnt++;
    total_cnt++;
    if (stall_err != 0)
      $display("FAIL ovr_stall_hold: got %0d want 0", stall_err);
    else pass_cnt++;
    total_cnt++;
    if (rx_q.size() != exp_q.size())
      $display("FAIL ovr_len: got %0d want %0d",
               rx_q.size(), exp_q.size());
    else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      total_cnt++;
      if (rx_q[i] !== exp_q[i])
        $display("FAIL ovr_byte %0d: got %h want %h",
                 i, rx_q[i], exp_q[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_last_byte_overrun();
    do_reset(2'd0);
    wait_clr(20, "lbo_clr0");
    CNT_BCD = 32'h12345678;
    LZ_SUPPRESS = 1'b0;
    model_msg(32'h12345678, 1'b0);
    wait_clr(20, "lbo_clr1");
    TX_READY = 1'b0;
    CNT_BCD = 32'h55555555;
    repeat (3) tick();
    TX_READY = 1'b1;
    wait_clr(20, "lbo_clr2");
    CNT_BCD = 32'h00000042;
    LZ_SUPPRESS = 1'b1;
    model_msg(32'h00000042, 1'b1);
    wait_clr(20, "lbo_clr3");
    repeat (10) tick();
    total_cnt++;
    if (ov_cnt != 1)
      $display("FAIL lbo_pulses: got %0d want 1", ov_cnt);
    else pass_cnt++;
    total_cnt++;
    if (rxc_q[9] - clr_q[1] != 12)
      $display("FAIL lbo_lf_cycle: got %0d want 12",
               rxc_q[9] - clr_q[1]);
    else pass_cnt++;
    total_cnt++;
    if (rx_q.size() != exp_q.size())
      $display("FAIL lbo_len: got %0d want %0d",
               rx_q.size(), exp_q.size());
    else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      total_cnt++;
      if (rx_q[i] !== exp_q[i])
        $display("FAIL lbo_byte %0d: got %h want %h",
                 i, rx_q[i], exp_q[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_async_reset();
    do_reset(2'd0);
    wait_clr(20, "ar_clr0");
    CNT_BCD = 32'h00000099;
    TX_READY = 1'b0;
    wait_clr(20, "ar_clr1");
    repeat (3) tick();
    total_cnt++;
    if ({TX_VALID, CNT_EN, GATE_LED} !== 3'b111)
      $display("FAIL ar_pre: got %b want 111",
               {TX_VALID, CNT_EN, GATE_LED});
    else pass_cnt++;
    #2;
    RSTn = 1'b0;
    #1;
    total_cnt++;
    if ({TX_VALID, CNT_EN, GATE_LED, CNT_CLR} !== 4'b0)
      $display("FAIL ar_async: got %b want 0000",
               {TX_VALID, CNT_EN, GATE_LED, CNT_CLR});
    else pass_cnt++;
    tick();
    tick();
    clr_q.delete();
    en_q.delete();
    rx_q.delete();
    rxc_q.delete();
    exp_q.delete();
    ov_cnt = 0;
    TX_READY = 1'b1;
    RSTn = 1'b1;
    tick();
    total_cnt++;
    if ({CNT_CLR, CNT_EN, TX_VALID} !== 3'b100)
      $display("FAIL ar_restart: got %b want 100",
               {CNT_CLR, CNT_EN, TX_VALID});
    else pass_cnt++;
    CNT_BCD = 32'h00000507;
    LZ_SUPPRESS = 1'b1;
    model_msg(32'h00000507, 1'b1);
    wait_clr(20, "ar_clr2");
    repeat (10) tick();
    total_cnt++;
    if (en_q[0] != 10)
      $display("FAIL ar_en_len: got %0d want 10", en_q[0]);
    else pass_cnt++;
    total_cnt++;
    if (rx_q.size() != exp_q.size())
      $display("FAIL ar_len: got %0d want %0d",
               rx_q.size(), exp_q.size());
    else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      total_cnt++;
      if (rx_q[i] !== exp_q[i])
        $display("FAIL ar_byte %0d: got %h want %h",
                 i, rx_q[i], exp_q[i]);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_gate_timing();
    test_gate_sel();
    test_tx_format();
    test_stall_random();
    test_overrun_hold();
    test_last_byte_overrun();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
